// File: rtl/mux_carry_out_logic.sv
// Ripple carry chain built from 2:1 muxes, one per operand bit, with the final
// carry registered on clk. Propagate (a^b) selects the incoming carry; otherwise a[i] is generate/kill.
module mux_carry_out_logic #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             c_out
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] p;
    logic             c_out_d;
    logic             c_out_q;

    assign carry[0] = c_in;

    // When p[i] is 0 the operand bits agree, so a[i] alone decides generate vs kill.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        assign p[i]       = a[i] ^ b[i];
        assign carry[i+1] = p[i] ? carry[i] : a[i];
    end

    assign c_out_d = carry[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_out_q <= 1'b0;
        end else begin
            c_out_q <= c_out_d;
        end
    end

    assign c_out = c_out_q;

endmodule

// File: tb/tb_mux_carry_out_logic.sv
// Bench for mux_carry_out_logic at WIDTH = 1, 4 and 8 driven side by side;
// expected carries are queued at drive time and compared one edge later.
module tb_mux_carry_out_logic;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a1, b1, c1;
    logic [3:0] a4, b4;
    logic       c4;
    logic [7:0] a8, b8;
    logic       c8;
    logic       c_out1, c_out4, c_out8;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    logic [0:0] exp1_q[$];
    logic [0:0] exp4_q[$];
    logic [0:0] exp8_q[$];

    // Majority of {a,b,c_in} indexed by the 3-bit value.
    logic [7:0] maj_tbl = 8'b1110_1000;

    mux_carry_out_logic #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .c_in(c1), .c_out(c_out1));
    mux_carry_out_logic #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .c_in(c4), .c_out(c_out4));
    mux_carry_out_logic #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .c_in(c8), .c_out(c_out8));

    always #5 clk = ~clk;

    function automatic logic carry_ref(input int w, input logic [7:0] x,
                                       input logic [7:0] y, input logic c);
        logic [8:0] s;
        s = {1'b0, x} + {1'b0, y} + {8'd0, c};
        return s[w];
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic e1, input logic e4, input logic e8);
        exp1_q.push_back(e1);
        exp4_q.push_back(e4);
        exp8_q.push_back(e8);
    endtask

    task automatic drive_all_ones();
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
        a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    endtask

    task automatic drive_rand_w4();
        a4 = 4'($urandom_range(0, 15));
        b4 = 4'($urandom_range(0, 15));
        c4 = 1'($urandom_range(0, 1));
    endtask

    task automatic drive_rand_w8();
        a8 = 8'($urandom_range(0, 255));
        b8 = 8'($urandom_range(0, 255));
        c8 = 1'($urandom_range(0, 1));
    endtask

    task automatic pop_check(input string tag, input logic obs, inout logic [0:0] q[$]);
        if (q.size() == 0) begin
            total_cnt++;
            fail_cnt++;
            $error("FAIL %s: observed %b expected <empty queue>", tag, obs);
        end else begin
            check(tag, obs, q.pop_front());
        end
    endtask

    task automatic clock_and_check(input string tag);
        @(posedge clk);
        #1;
        pop_check({tag, "_w1"}, c_out1, exp1_q);
        pop_check({tag, "_w4"}, c_out4, exp4_q);
        pop_check({tag, "_w8"}, c_out8, exp8_q);
    endtask

    logic [3:0] d_a4[4]  = '{4'hF, 4'hF, 4'h8, 4'h7};
    logic [3:0] d_b4[4]  = '{4'h0, 4'h0, 4'h8, 4'h0};
    logic       d_c4[4]  = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic       d_e4[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};

    initial begin
        // Reset held with all-ones inputs: c_out must stay 0 through edges.
        rst_n = 1'b0;
        drive_all_ones();
        #1;
        check("reset_async_w1", c_out1, 1'b0);
        check("reset_async_w4", c_out4, 1'b0);
        check("reset_async_w8", c_out8, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold_w1", c_out1, 1'b0);
            check("reset_hold_w4", c_out4, 1'b0);
            check("reset_hold_w8", c_out8, 1'b0);
        end

        rst_n = 1'b1;
        push_exp(1'b1, 1'b1, 1'b1);
        clock_and_check("reset_release");

        // WIDTH=1 exhaustive sweep against the majority table.
        for (int v = 0; v < 8; v++) begin
            logic [2:0] vb;
            vb = 3'(v);
            {a1, b1, c1} = vb;
            drive_rand_w4();
            drive_rand_w8();
            push_exp(maj_tbl[v], carry_ref(4, {4'd0, a4}, {4'd0, b4}, c4),
                     carry_ref(8, a8, b8, c8));
            clock_and_check("w1_sweep");
        end

        // WIDTH=4 full propagate and generate/kill cases.
        for (int k = 0; k < 4; k++) begin
            a4 = d_a4[k]; b4 = d_b4[k]; c4 = d_c4[k];
            a1 = 1'($urandom_range(0, 1));
            b1 = 1'($urandom_range(0, 1));
            c1 = 1'($urandom_range(0, 1));
            drive_rand_w8();
            push_exp(carry_ref(1, {7'd0, a1}, {7'd0, b1}, c1), d_e4[k],
                     carry_ref(8, a8, b8, c8));
            clock_and_check("w4_directed");
        end

        // Mid-run reset pulse between edges, then recovery on the next edge.
        drive_all_ones();
        push_exp(1'b1, 1'b1, 1'b1);
        clock_and_check("pre_midreset");
        rst_n = 1'b0;
        #1;
        check("midreset_w1", c_out1, 1'b0);
        check("midreset_w4", c_out4, 1'b0);
        check("midreset_w8", c_out8, 1'b0);
        #1;
        rst_n = 1'b1;
        #1;
        check("midreset_hold_w8", c_out8, 1'b0);
        push_exp(1'b1, 1'b1, 1'b1);
        clock_and_check("post_midreset");

        // Random vectors; inputs also disturbed mid-cycle to confirm c_out holds.
        for (int n = 0; n < 1000; n++) begin
            logic prev8;
            a1 = 1'($urandom_range(0, 1));
            b1 = 1'($urandom_range(0, 1));
            c1 = 1'($urandom_range(0, 1));
            drive_rand_w4();
            drive_rand_w8();
            push_exp(carry_ref(1, {7'd0, a1}, {7'd0, b1}, c1),
                     carry_ref(4, {4'd0, a4}, {4'd0, b4}, c4),
                     carry_ref(8, a8, b8, c8));
            clock_and_check("random");
            if (n % 100 == 0) begin
                prev8 = carry_ref(8, a8, b8, c8);
                a8 = ~a8;
                b8 = ~b8;
                c8 = ~c8;
                #2;
                check("midcycle_hold_w8", c_out8, prev8);
                a8 = ~a8;
                b8 = ~b8;
                c8 = ~c8;
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
